// File: rtl/fastserial_pkg.sv
// Shared definitions for the fast-serial receiver: FSM encoding and frame geometry.
package fastserial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_SRC  = 2'd2
   } rx_state_e;

   localparam int unsigned DATA_BITS_DEFAULT = 8;
   // Start bit + payload + source bit; no stop bit.
   localparam int unsigned FRAME_BITS = DATA_BITS_DEFAULT + 2;

endpackage

// File: rtl/fastserial_rx_fifo.sv
// First-word-fall-through receive buffer; pointers carry an extra MSB for full/empty.
module fastserial_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             wr_en, rd_en;

   assign o_empty = (wr_q == rd_q);
   assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rd_en   = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot the push lands in, so a full buffer still accepts.
   assign wr_en   = i_push & (~o_full | rd_en);
   assign wr_d    = wr_q + {{AW{1'b0}}, wr_en};
   assign rd_d    = rd_q + {{AW{1'b0}}, rd_en};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = o_empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/fastserial_rx.sv
// Fast-serial frame receiver: start(0), DATA_BITS LSB first, source bit, into a FIFO.
// Define FASTSERIAL_RX_SYNC_EN to add 2-flop synchronizers on i_fsclk and i_fsdo.
module fastserial_rx
   import fastserial_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fsclk,
   input  logic                 i_fsdo,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_src,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_overrun,
   input  logic                 i_clr_overrun,
   output logic [1:0]           o_dbg_state
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [1:0]           rst_sync_q;
   logic                 rst_n;
   logic                 fsclk_s, fsdo_s;
   logic                 fsclk_prev_q;
   logic                 sample;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 push_req;
   logic [DATA_BITS:0]   push_word;
   logic [DATA_BITS:0]   head_word;
   logic                 fifo_full, fifo_empty;
   logic                 pop;
   logic                 ovr_q, ovr_d;

   // Assert asynchronously, release two i_clk edges later.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

`ifdef FASTSERIAL_RX_SYNC_EN
   logic [1:0] fsclk_sync_q, fsdo_sync_q;
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         fsclk_sync_q <= 2'b11;
         fsdo_sync_q  <= 2'b11;
      end else begin
         fsclk_sync_q <= {fsclk_sync_q[0], i_fsclk};
         fsdo_sync_q  <= {fsdo_sync_q[0], i_fsdo};
      end
   end
   assign fsclk_s = fsclk_sync_q[1];
   assign fsdo_s  = fsdo_sync_q[1];
`else
   assign fsclk_s = i_fsclk;
   assign fsdo_s  = i_fsdo;
`endif

   // Previous level resets high so a line already high after reset is not an edge.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) fsclk_prev_q <= 1'b1;
      else        fsclk_prev_q <= fsclk_s;
   end
   assign sample = fsclk_s & ~fsclk_prev_q;

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (sample && !fsdo_s) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_DATA: begin
            if (sample) begin
               shift_d = {fsdo_s, shift_q[DATA_BITS-1:1]};
               if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = ST_SRC;
               else                                cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_SRC: begin
            if (sample) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      push_req  = (state_q == ST_SRC) && sample;
      push_word = {fsdo_s, shift_q};
   end

   assign pop   = o_valid & i_ready;
   // A set in the same cycle as a clear wins.
   assign ovr_d = (push_req & fifo_full & ~pop) | (ovr_q & ~i_clr_overrun);

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) ovr_q <= 1'b0;
      else        ovr_q <= ovr_d;
   end

   fastserial_rx_fifo #(
      .WIDTH (DATA_BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (rst_n),
      .i_push  (push_req),
      .i_wdata (push_word),
      .i_pop   (pop),
      .o_rdata (head_word),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign o_valid     = ~fifo_empty;
   assign o_data      = head_word[DATA_BITS-1:0];
   assign o_src       = head_word[DATA_BITS];
   assign o_overrun   = ovr_q;
   assign o_dbg_state = state_q;

endmodule

// File: doc/fastserial_rx.md
FASTSERIAL_RX -- requirements
Module: fastserial_rx

Interface
REQ-001 SHALL: parameter DATA_BITS, default 8, payload bits per frame.
REQ-002 SHALL: parameter FIFO_DEPTH, default 4, receive-buffer entries (power of two, >= 2).
REQ-003 SHALL: i_clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 SHALL: i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL: i_fsclk  input  1  fast-serial clock from the fast-serial clock generator; a level sampled in i_clk.
REQ-006 SHALL: i_fsdo  input  1  serial data from the far end; idles high.
REQ-007 SHALL: o_data  output  DATA_BITS  head-of-buffer payload.
REQ-008 SHALL: o_src  output  1  head-of-buffer source bit.
REQ-009 SHALL: o_valid  output  1  buffer non-empty; o_data and o_src are valid.
REQ-010 SHALL: i_ready  input  1  consumer accepts the head when o_valid and i_ready are both high.
REQ-011 SHALL: o_overrun  output  1  sticky: a frame was dropped because the buffer was full.
REQ-012 SHALL: i_clr_overrun  input  1  one-cycle pulse that clears o_overrun.

Function
REQ-013 SHALL: define the sample event as a rising edge of i_fsclk, detected as current i_fsclk=1 and previous registered value=0; every bit is sampled on the sample event only.
REQ-014 SHALL: use frame format start bit (0), then DATA_BITS data bits LSB first, then one source bit; there is no stop bit.
REQ-015 SHALL: implement FSM states IDLE, DATA and SRC; IDLE->DATA on a sample event with i_fsdo=0; a sample event with i_fsdo=1 in IDLE is ignored.
REQ-016 SHALL: in DATA, shift one bit per sample event with a bit counter of width clog2(DATA_BITS); DATA->SRC after bit DATA_BITS-1.
REQ-017 SHALL: in SRC, capture the source bit, then on the same cycle push {src,data} to the buffer if not full, else drop the frame and set o_overrun; SRC->IDLE.
REQ-018 SHALL: make a pushed frame visible on o_valid exactly 1 cycle after the SRC sample event.
REQ-019 SHALL: operate the buffer as a FIFO; a pop occurs when o_valid and i_ready are both high, and the next entry is presented the following cycle.
REQ-020 SHALL: when a push and a pop occur in the same cycle with the buffer full, accept both (no overrun) and leave the occupancy unchanged.
REQ-021 SHALL: wrap the read and write pointers modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer MSB.
REQ-022 SHALL: when set and clear coincide (i_clr_overrun with an overrun in the same cycle), leave o_overrun set.
REQ-023 SHALL: place no throughput limit beyond one frame per DATA_BITS+2 sample events.

Reset
REQ-024 SHALL: on i_rst_n low, immediately force the FSM to IDLE, clear the bit counter, shift register and FIFO pointers, and set the previous i_fsclk register to 1.
REQ-025 SHALL: reset values are o_valid=0, o_overrun=0, o_data=0 and o_src=0.
REQ-026 SHALL: on reset mid-frame, discard the partial frame and discard all buffered entries.
REQ-027 SHALL: release reset synchronously to i_clk within the module (2-flop reset synchronizer); the first sample event SHALL NOT be recognised before the second i_clk edge after deassertion.

Configuration
REQ-028 SHALL: with FASTSERIAL_RX_SYNC_EN defined, pass i_fsdo and i_fsclk through 2-flop synchronizers before edge detection, adding 2 cycles to the latency of REQ-018.
REQ-029 SHALL: without FASTSERIAL_RX_SYNC_EN, feed i_fsdo and i_fsclk to edge detection unsynchronized; this is legal only when both come from the i_clk domain.

Structure
REQ-030 SHALL: provide a shared package fastserial_pkg holding the FSM state encoding (IDLE/DATA/SRC), DATA_BITS default and frame length constant DATA_BITS+2.
REQ-031 SHALL: implement the buffer as sub-module fastserial_rx_fifo (synchronous, width DATA_BITS+1, depth FIFO_DEPTH, first-word-fall-through).

Verification
REQ-032 SHALL: cover divider 4, frame start=0, data 0xA5 LSB first, src=1 -> o_valid 1 cycle after the last sample event, o_data=0xA5, o_src=1.
REQ-033 SHALL: cover i_fsdo held high for 20 fsclk periods -> o_valid stays 0 and FSM stays IDLE.
REQ-034 SHALL: cover i_ready=0 while 5 frames 0x01..0x05 are sent -> 4 frames buffered, o_overrun=1; draining yields 0x01..0x04 in order.
REQ-035 SHALL: cover i_clr_overrun pulsed on the same cycle as a new overrun -> o_overrun remains 1; a pulse on the next cycle clears it.
REQ-036 SHALL: cover i_rst_n asserted after 4 data bits of 0x3C -> outputs reset immediately; a following full frame 0x5A is received correctly.
REQ-037 SHALL: cover a full buffer with i_ready=1 on the push cycle of frame 0x77 -> no overrun, 0x77 is read out as the fourth entry after the 3 remaining.
